alu_adder: RTL and testbench

- Registered 32-bit add/subtract unit for the EX stage of the processor datapath.
- Computes opr0_i + opr1_i, or opr0_i - opr1_i when minus_i is set.
- Produces zero, positive, negative and carry/overflow flags alongside the result.
- One clock of latency; the valid_i/valid_o qualifier travels with the data.

---
 rtl/alu_adder.sv | 101 ++++++++++
 tb/tb_alu_adder.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/alu_adder.sv
`default_nettype none
// ============================================================================
// Module      : alu_adder
// Description : Registered WIDTH-bit carry-select add/subtract unit with
//               zero/pos/neg/carry flags. Optional macro
//               ALU_ADDER_SIGNED_OVF_EN adds a two's-complement overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_adder #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] opr0_i,
    input  logic [WIDTH-1:0] opr1_i,
    input  logic             minus_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_flag_o,
    output logic             pos_flag_o,
    output logic             neg_flag_o,
`ifdef ALU_ADDER_SIGNED_OVF_EN
    output logic             signed_overflow_flag_o,
`endif
    output logic             overflow_flag_o
);

    localparam int c_NIBBLES = WIDTH / 4;

    // 4-bit carry-lookahead slice; returns {cout, sum[3:0]}.
    function automatic logic [4:0] cla4(input logic [3:0] a,
                                        input logic [3:0] b,
                                        input logic       cin);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
        return {c[4], p ^ c[3:0]};
    endfunction

    logic [WIDTH-1:0]    w_opb;
    logic [WIDTH-1:0]    w_sum;
    logic [c_NIBBLES:0]  w_carry;

    assign w_opb      = minus_i ? ~opr1_i : opr1_i;
    assign w_carry[0] = minus_i;

    // Both slice results are ready before the carry ripples in; only the mux sits on the chain.
    generate
        for (genvar i = 0; i < c_NIBBLES; i++) begin : g_nibble
            logic [4:0] w_res0;
            logic [4:0] w_res1;
            assign w_res0 = cla4(opr0_i[4*i +: 4], w_opb[4*i +: 4], 1'b0);
            assign w_res1 = cla4(opr0_i[4*i +: 4], w_opb[4*i +: 4], 1'b1);
            assign w_sum[4*i +: 4] = w_carry[i] ? w_res1[3:0] : w_res0[3:0];
            assign w_carry[i+1]    = w_carry[i] ? w_res1[4]   : w_res0[4];
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o         <= 1'b0;
            result_o        <= '0;
            zero_flag_o     <= 1'b0;
            pos_flag_o      <= 1'b0;
            neg_flag_o      <= 1'b0;
            overflow_flag_o <= 1'b0;
        end else begin
            valid_o <= valid_i;
            if (valid_i) begin
                result_o        <= w_sum;
                zero_flag_o     <= ~|w_sum;
                pos_flag_o      <= ~w_sum[WIDTH-1];
                neg_flag_o      <= w_sum[WIDTH-1];
                overflow_flag_o <= w_carry[c_NIBBLES];
            end
        end
    end

`ifdef ALU_ADDER_SIGNED_OVF_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            signed_overflow_flag_o <= 1'b0;
        end else if (valid_i) begin
            signed_overflow_flag_o <= (opr0_i[WIDTH-1] == w_opb[WIDTH-1])
                                   && (w_sum[WIDTH-1] != opr0_i[WIDTH-1]);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_adder.sv
`default_nettype none
// Directed testbench for alu_adder: add/sub vectors, hold, throughput and reset.
module tb_alu_adder;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic [31:0] opr0_i;
    logic [31:0] opr1_i;
    logic        minus_i;
    logic        valid_o;
    logic [31:0] result_o;
    logic        zero_flag_o;
    logic        pos_flag_o;
    logic        neg_flag_o;
    logic        overflow_flag_o;
`ifdef ALU_ADDER_SIGNED_OVF_EN
    logic        signed_overflow_flag_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    alu_adder #(.WIDTH(32)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .valid_i         (valid_i),
        .opr0_i          (opr0_i),
        .opr1_i          (opr1_i),
        .minus_i         (minus_i),
        .valid_o         (valid_o),
        .result_o        (result_o),
        .zero_flag_o     (zero_flag_o),
        .pos_flag_o      (pos_flag_o),
        .neg_flag_o      (neg_flag_o),
`ifdef ALU_ADDER_SIGNED_OVF_EN
        .signed_overflow_flag_o (signed_overflow_flag_o),
`endif
        .overflow_flag_o (overflow_flag_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Checks valid, result and the four flags packed as {zero,pos,neg,ovf}.
    task automatic chk_out(input string tag, input logic v, input logic [31:0] res,
                           input logic [3:0] flags);
        chk({tag, ".valid"}, 64'(valid_o), 64'(v));
        chk({tag, ".result"}, 64'(result_o), 64'(res));
        chk({tag, ".flags"},
            64'({zero_flag_o, pos_flag_o, neg_flag_o, overflow_flag_o}), 64'(flags));
    endtask

    // Drive one cycle of inputs on the falling edge, then sample just after the rising edge.
    task automatic step(input logic r, input logic v, input logic m,
                        input logic [31:0] a, input logic [31:0] b);
        @(negedge clk_i);
        rst_i   = r;
        valid_i = v;
        minus_i = m;
        opr0_i  = a;
        opr1_i  = b;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        logic [32:0] ref_full;
        logic [31:0] a;
        logic [31:0] b;
        logic        m;
        logic [31:0] last_res;
        logic [3:0]  last_flags;

        rst_i = 1'b1; valid_i = 1'b0; minus_i = 1'b0; opr0_i = '0; opr1_i = '0;
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        chk_out("reset", 1'b0, 32'h0, 4'b0000);

        step(1'b0, 1'b1, 1'b0, 32'h0000_0005, 32'h0000_0003);
        chk_out("add5p3", 1'b1, 32'h0000_0008, 4'b0100);

        step(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
        chk_out("addwrap", 1'b1, 32'h0000_0000, 4'b1101);

        step(1'b0, 1'b1, 1'b1, 32'd5, 32'd3);
        chk_out("sub5m3", 1'b1, 32'h0000_0002, 4'b0101);

        step(1'b0, 1'b1, 1'b1, 32'd3, 32'd5);
        chk_out("sub3m5", 1'b1, 32'hFFFF_FFFE, 4'b0010);

        // Carry propagating through every nibble boundary.
        step(1'b0, 1'b1, 1'b0, 32'h0FFF_FFFF, 32'h0000_0001);
        chk_out("ripple", 1'b1, 32'h1000_0000, 4'b0100);

        step(1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000);
        chk_out("subeq", 1'b1, 32'h0000_0000, 4'b1101);

        for (int i = 0; i < 10; i++) begin
            a = $urandom;
            b = $urandom;
            m = 1'($urandom_range(0, 1));
            ref_full = {1'b0, a} + {1'b0, (m ? ~b : b)} + 33'(m);
            step(1'b0, 1'b1, m, a, b);
            chk_out($sformatf("rand%0d", i), 1'b1, ref_full[31:0],
                    {ref_full[31:0] == 32'h0, ~ref_full[31], ref_full[31], ref_full[32]});
        end
        last_res   = ref_full[31:0];
        last_flags = {ref_full[31:0] == 32'h0, ~ref_full[31], ref_full[31], ref_full[32]};

        step(1'b0, 1'b0, 1'b0, 32'h1111_1111, 32'h2222_2222);
        chk_out("hold0", 1'b0, last_res, last_flags);
        step(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0000_0001);
        chk_out("hold1", 1'b0, last_res, last_flags);

        step(1'b1, 1'b1, 1'b0, 32'h1234_5678, 32'h0000_0001);
        chk_out("rstmid", 1'b0, 32'h0, 4'b0000);

        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk_out("postrst", 1'b0, 32'h0, 4'b0000);

`ifdef ALU_ADDER_SIGNED_OVF_EN
        step(1'b0, 1'b1, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001);
        chk_out("sovf_add", 1'b1, 32'h8000_0000, 4'b0010);
        chk("sovf_add.sovf", 64'(signed_overflow_flag_o), 64'd1);
        step(1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'h0000_0001);
        chk("sovf_sub.sovf", 64'(signed_overflow_flag_o), 64'd1);
        chk("sovf_sub.result", 64'(result_o), 64'h7FFF_FFFF);
        step(1'b0, 1'b1, 1'b0, 32'd5, 32'd3);
        chk("sovf_none.sovf", 64'(signed_overflow_flag_o), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
